// File: rtl/ula_seq_ctrl.sv
// ula_seq_ctrl: multi-cycle sequencer around the stack-machine ALU op set (shift-add MULT, restoring DIV).
// Optional macro ULA_SQRT_EN adds an iterative integer square root on funct 00011.
module ula_seq_ctrl #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [4:0]   funct,
   input  logic [1:0]   shift_ctrl,
   input  logic         enable32,
   input  logic [W-1:0] t_in,
   input  logic [W-1:0] y_in,
   output logic [W-1:0] result,
   output logic [W-1:0] result_hi,
   output logic         flag_c,
   output logic         flag_z,
   output logic         flag_dz,
   output logic         busy,
   output logic         done
);

   localparam int unsigned CW = 5;

   localparam logic [4:0] F_BYPT = 5'b00000;
   localparam logic [4:0] F_AND  = 5'b00100;
   localparam logic [4:0] F_SUB  = 5'b01000;
   localparam logic [4:0] F_OR   = 5'b01100;
   localparam logic [4:0] F_ADD  = 5'b10000;
   localparam logic [4:0] F_XOR  = 5'b10100;
   localparam logic [4:0] F_NSUB = 5'b11000;
   localparam logic [4:0] F_BYPY = 5'b11100;
   localparam logic [4:0] F_MULT = 5'b00010;
   localparam logic [4:0] F_DIV  = 5'b00001;
`ifdef ULA_SQRT_EN
   localparam logic [4:0] F_SQRT = 5'b00011;
`endif

   typedef enum logic [1:0] {S_IDLE, S_ITER, S_FINISH} state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   last_cnt;
   logic [W-1:0]    t_r, y_r;
   logic [4:0]      funct_r;
   logic [1:0]      sh_r;
   logic            en32_r;
   logic [W:0]      acc_hi;
   logic [W-1:0]    acc_lo;
   logic [W:0]      step_hi;
   logic [W-1:0]    step_lo;
   logic [W:0]      madd, dshift, sum;
   logic [W-1:0]    raw_lo, raw_hi, shifted;
   logic            raw_c, raw_dz;
   logic            iter_op;
`ifdef ULA_SQRT_EN
   logic [7:0]      root, step_root;
   logic [W:0]      srem, trial;
`endif

`ifdef ULA_SQRT_EN
   assign last_cnt = (funct_r == F_SQRT) ? CW'(7) : CW'(15);
   assign iter_op  = (funct == F_MULT) || (funct == F_SQRT) || (funct == F_DIV && y_in != '0);
`else
   assign last_cnt = CW'(15);
   assign iter_op  = (funct == F_MULT) || (funct == F_DIV && y_in != '0);
`endif

   // One iteration of the active engine: acc_hi is partial product / remainder, acc_lo the shifting operand
   always_comb begin
      step_hi = acc_hi;
      step_lo = acc_lo;
      madd    = acc_hi + (acc_lo[0] ? {1'b0, t_r} : (W+1)'(0));
      dshift  = {acc_hi[W-1:0], acc_lo[W-1]};
`ifdef ULA_SQRT_EN
      step_root = root;
      srem      = {acc_hi[W-3:0], acc_lo[W-1:W-2]};
      trial     = (W+1)'({root, 2'b01});
`endif
      case (funct_r)
         F_MULT: begin
            step_hi = {1'b0, madd[W:1]};
            step_lo = {madd[0], acc_lo[W-1:1]};
         end
         F_DIV: begin
            if (dshift >= {1'b0, y_r}) begin
               step_hi = dshift - {1'b0, y_r};
               step_lo = {acc_lo[W-2:0], 1'b1};
            end else begin
               step_hi = dshift;
               step_lo = {acc_lo[W-2:0], 1'b0};
            end
         end
`ifdef ULA_SQRT_EN
         F_SQRT: begin
            step_lo = {acc_lo[W-3:0], 2'b00};
            if (srem >= trial) begin
               step_hi   = srem - trial;
               step_root = {root[6:0], 1'b1};
            end else begin
               step_hi   = srem;
               step_root = {root[6:0], 1'b0};
            end
         end
`endif
         default: ;
      endcase
   end

   // Final result selection, then the post-op shift on the primary word
   always_comb begin
      raw_lo  = t_r;
      raw_hi  = '0;
      raw_c   = 1'b0;
      raw_dz  = 1'b0;
      sum     = {1'b0, t_r} + {1'b0, y_r};
      shifted = '0;
      case (funct_r)
         F_BYPT: raw_lo = t_r;
         F_AND:  raw_lo = t_r & y_r;
         F_OR:   raw_lo = t_r | y_r;
         F_XOR:  raw_lo = t_r ^ y_r;
         F_BYPY: raw_lo = y_r;
         F_ADD: begin
            raw_lo = sum[W-1:0];
            raw_c  = sum[W];
         end
         F_SUB: begin
            raw_lo = t_r - y_r;
            raw_c  = (t_r < y_r);
         end
         F_NSUB: begin
            raw_lo = y_r - t_r;
            raw_c  = (y_r < t_r);
         end
         F_MULT: begin
            raw_lo = acc_lo;
            raw_hi = en32_r ? acc_hi[W-1:0] : '0;
         end
         F_DIV: begin
            if (y_r == '0) begin
               raw_lo = '1;
               raw_hi = en32_r ? t_r : '0;
               raw_dz = 1'b1;
            end else begin
               raw_lo = acc_lo;
               raw_hi = en32_r ? acc_hi[W-1:0] : '0;
            end
         end
`ifdef ULA_SQRT_EN
         F_SQRT: begin
            raw_lo = W'(root);
            raw_c  = (acc_hi != '0);
         end
`endif
         default: raw_lo = t_r;
      endcase
      case (sh_r)
         2'b01:   shifted = {1'b0, raw_lo[W-1:1]};
         2'b10:   shifted = {raw_lo[W-2:0], 1'b0};
         2'b11:   shifted = {raw_lo[W-1], raw_lo[W-1:1]};
         default: shifted = raw_lo;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         t_r       <= '0;
         y_r       <= '0;
         funct_r   <= '0;
         sh_r      <= '0;
         en32_r    <= 1'b0;
         acc_hi    <= '0;
         acc_lo    <= '0;
         result    <= '0;
         result_hi <= '0;
         flag_c    <= 1'b0;
         flag_z    <= 1'b0;
         flag_dz   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
`ifdef ULA_SQRT_EN
         root      <= '0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  t_r     <= t_in;
                  y_r     <= y_in;
                  funct_r <= funct;
                  sh_r    <= shift_ctrl;
                  en32_r  <= enable32;
                  cnt     <= '0;
                  acc_hi  <= '0;
                  acc_lo  <= (funct == F_MULT) ? y_in : t_in;
                  busy    <= 1'b1;
                  state   <= iter_op ? S_ITER : S_FINISH;
`ifdef ULA_SQRT_EN
                  root    <= '0;
`endif
               end
            end
            S_ITER: begin
               acc_hi <= step_hi;
               acc_lo <= step_lo;
`ifdef ULA_SQRT_EN
               root   <= step_root;
`endif
               cnt    <= cnt + CW'(1);
               if (cnt == last_cnt) state <= S_FINISH;
            end
            S_FINISH: begin
               result    <= shifted;
               result_hi <= raw_hi;
               flag_c    <= raw_c;
               flag_z    <= (shifted == '0);
               flag_dz   <= raw_dz;
               busy      <= 1'b0;
               done      <= 1'b1;
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ula_seq_ctrl.sv
// Directed-vector bench for ula_seq_ctrl; expectations follow ULA_SQRT_EN when it is defined.
module tb_ula_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst, start, enable32;
   logic [4:0]  funct;
   logic [1:0]  shift_ctrl;
   logic [15:0] t_in, y_in, result, result_hi;
   logic        flag_c, flag_z, flag_dz, busy, done;

   int n_checks = 0;
   int n_fail   = 0;

   ula_seq_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .funct(funct), .shift_ctrl(shift_ctrl),
      .enable32(enable32), .t_in(t_in), .y_in(y_in), .result(result), .result_hi(result_hi),
      .flag_c(flag_c), .flag_z(flag_z), .flag_dz(flag_dz), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive a request across edge 0 and confirm busy rises
   task automatic issue(input string tag, input logic [4:0] f, input logic [1:0] sh,
                        input logic e32, input logic [15:0] t, input logic [15:0] y);
      start = 1'b1; funct = f; shift_ctrl = sh; enable32 = e32; t_in = t; y_in = y;
      tick();
      start = 1'b0; t_in = 16'h5A5A; y_in = 16'hA5A5; funct = 5'b10000;
      check({tag, "_busy_rise"}, busy, 1'b1);
   endtask

   // Wait for done; inj>0 drives an extra start sampled at that edge number
   task automatic wait_done(input string tag, input int inj, output int lat);
      bit busy_ok = 1'b1;
      lat = 0;
      while (!done && lat < 40) begin
         if (lat + 1 == inj) begin
            start = 1'b1; funct = 5'b10000; t_in = 16'h0001; y_in = 16'h0001;
         end
         tick();
         start = 1'b0;
         lat++;
         if (!done && !busy) busy_ok = 1'b0;
      end
      if (!done) check({tag, "_timeout"}, 1'b0, 1'b1);
      check({tag, "_busy_held"}, busy_ok, 1'b1);
      check({tag, "_busy_fall"}, busy, 1'b0);
   endtask

   typedef struct {
      logic [4:0]  f;
      logic [1:0]  sh;
      logic [15:0] t, y, res;
      logic        c;
   } vec_t;

   vec_t vecs[12];

   initial begin
      int lat;
      rst = 1'b1; start = 1'b0; funct = '0; shift_ctrl = '0; enable32 = 1'b0; t_in = '0; y_in = '0;
      tick(); tick();
      check("rst_result", result, 16'h0);
      check("rst_hi", result_hi, 16'h0);
      check("rst_flags", {flag_c, flag_z, flag_dz}, 3'b000);
      check("rst_busy_done", {busy, done}, 2'b00);
      rst = 1'b0;
      tick();

      issue("add", 5'b10000, 2'b00, 1'b0, 16'hFFFF, 16'h0001);
      wait_done("add", 0, lat);
      check("add_lat", lat, 1);
      check("add_res", result, 16'h0000);
      check("add_flags", {flag_c, flag_z, flag_dz}, 3'b110);

      issue("sub", 5'b01000, 2'b11, 1'b0, 16'd5, 16'd7);
      wait_done("sub", 0, lat);
      check("sub_lat", lat, 1);
      check("sub_res", result, 16'hFFFF);
      check("sub_flags", {flag_c, flag_z}, 2'b10);
      // Issued in the done cycle: must be accepted
      issue("b2b", 5'b10000, 2'b00, 1'b0, 16'd3, 16'd4);
      check("b2b_done_low", done, 1'b0);
      wait_done("b2b", 0, lat);
      check("b2b_lat", lat, 1);
      check("b2b_res", result, 16'd7);

      issue("mult", 5'b00010, 2'b00, 1'b1, 16'h0123, 16'h0100);
      wait_done("mult", 3, lat);
      check("mult_lat", lat, 17);
      check("mult_lo", result, 16'h2300);
      check("mult_hi", result_hi, 16'h0001);
      check("mult_c", flag_c, 1'b0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("mult_no_queue", {busy, done}, 2'b00);
      end
      check("hold_res", result, 16'h2300);

      issue("multmax", 5'b00010, 2'b00, 1'b1, 16'hFFFF, 16'hFFFF);
      wait_done("multmax", 0, lat);
      check("multmax_res", {result_hi, result}, 32'hFFFE0001);

      issue("mult16", 5'b00010, 2'b10, 1'b0, 16'hFFFF, 16'hFFFF);
      wait_done("mult16", 0, lat);
      check("mult16_res", {result_hi, result}, 32'h00000002);

      issue("div", 5'b00001, 2'b00, 1'b1, 16'd100, 16'd7);
      wait_done("div", 0, lat);
      check("div_lat", lat, 17);
      check("div_q", result, 16'd14);
      check("div_r", result_hi, 16'd2);
      check("div_dz", flag_dz, 1'b0);

      issue("divmax", 5'b00001, 2'b00, 1'b1, 16'hFFFF, 16'h0001);
      wait_done("divmax", 0, lat);
      check("divmax_res", {result_hi, result}, 32'h0000FFFF);

      issue("dz", 5'b00001, 2'b00, 1'b1, 16'd9, 16'd0);
      wait_done("dz", 0, lat);
      check("dz_lat", lat, 1);
      check("dz_res", result, 16'hFFFF);
      check("dz_hi", result_hi, 16'd9);
      check("dz_flags", {flag_c, flag_z, flag_dz}, 3'b001);

      issue("sqrt", 5'b00011, 2'b00, 1'b0, 16'd144, 16'd3);
      wait_done("sqrt", 0, lat);
`ifdef ULA_SQRT_EN
      check("sqrt_lat", lat, 9);
      check("sqrt_res", result, 16'd12);
      check("sqrt_c", flag_c, 1'b0);
      issue("sqrt2", 5'b00011, 2'b00, 1'b0, 16'hFFFF, 16'd0);
      wait_done("sqrt2", 0, lat);
      check("sqrt2_res", {result, 15'b0, flag_c}, {16'd255, 16'd1});
`else
      check("sqrt_lat", lat, 1);
      check("sqrt_res", result, 16'd144);
      check("sqrt_c", flag_c, 1'b0);
`endif

      vecs[0]  = '{5'b00100, 2'b00, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0};
      vecs[1]  = '{5'b01100, 2'b00, 16'hF0F0, 16'h0F00, 16'hFFF0, 1'b0};
      vecs[2]  = '{5'b10100, 2'b00, 16'hAAAA, 16'hAAAA, 16'h0000, 1'b0};
      vecs[3]  = '{5'b11000, 2'b00, 16'd3,    16'd10,   16'd7,    1'b0};
      vecs[4]  = '{5'b11000, 2'b00, 16'd10,   16'd3,    16'hFFF9, 1'b1};
      vecs[5]  = '{5'b11100, 2'b01, 16'h1111, 16'h8001, 16'h4000, 1'b0};
      vecs[6]  = '{5'b00000, 2'b10, 16'h8001, 16'h1111, 16'h0002, 1'b0};
      vecs[7]  = '{5'b10000, 2'b11, 16'h8000, 16'h8000, 16'h0000, 1'b1};
      vecs[8]  = '{5'b00101, 2'b00, 16'h1234, 16'h4321, 16'h1234, 1'b0};
      vecs[9]  = '{5'b01000, 2'b11, 16'd7,    16'd5,    16'd1,    1'b0};
      vecs[10] = '{5'b00000, 2'b11, 16'h8000, 16'h0000, 16'hC000, 1'b0};
      vecs[11] = '{5'b01000, 2'b00, 16'd9,    16'd9,    16'd0,    1'b0};
      foreach (vecs[i]) begin
         issue($sformatf("vec%0d", i), vecs[i].f, vecs[i].sh, 1'b1, vecs[i].t, vecs[i].y);
         wait_done($sformatf("vec%0d", i), 0, lat);
         check($sformatf("vec%0d_lat", i), lat, 1);
         check($sformatf("vec%0d_res", i), result, vecs[i].res);
         check($sformatf("vec%0d_flags", i), {result_hi, flag_c, flag_z, flag_dz},
               {16'h0, vecs[i].c, (vecs[i].res == 16'h0), 1'b0});
      end

      // Abort a DIV at cycle 5
      issue("abort", 5'b00001, 2'b00, 1'b1, 16'd100, 16'd7);
      for (int i = 0; i < 4; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_busy_done", {busy, done}, 2'b00);
      check("abort_outs", {result, result_hi, flag_c, flag_z, flag_dz}, 35'h0);
      for (int i = 0; i < 20; i++) begin
         tick();
         check("abort_no_done", {busy, done}, 2'b00);
      end
      issue("post", 5'b10000, 2'b00, 1'b0, 16'd2, 16'd3);
      wait_done("post", 0, lat);
      check("post_lat", lat, 1);
      check("post_res", result, 16'd5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
